// File: rtl/fmm_reduce_pkg.sv
// Shared constants and enums for the fmm reduce kernel M_e accumulation controller.
//   DataWidth    - word width of M_e
//   AddressWidth - RAM address width
//   AddressRange - number of M_e words; the clear sweep covers 0..AddressRange-1
package fmm_reduce_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned AddressWidth = 17;
  localparam int unsigned AddressRange = 102400;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    CLEAR
  } state_e;

  typedef enum logic {
    OP_ACC,
    OP_RD
  } op_e;

endpackage

// File: rtl/fmm_reduce_kernel_m_e_accum_ctrl_if.sv
// Request/response streams between the requesters and the M_e accumulation controller.
//   acc_*     - accumulate stream (valid/ready, address, addend)
//   rd_req_*  - readout request stream (valid/ready, address)
//   rd_resp_* - readout response (valid, data), no backpressure
// master: requester side; slave: controller side.
interface fmm_reduce_kernel_m_e_accum_ctrl_if #(
  parameter int unsigned DataWidth    = fmm_reduce_pkg::DataWidth,
  parameter int unsigned AddressWidth = fmm_reduce_pkg::AddressWidth
) ();

  logic                    acc_valid;
  logic                    acc_ready;
  logic [AddressWidth-1:0] acc_addr;
  logic [DataWidth-1:0]    acc_data;

  logic                    rd_req_valid;
  logic                    rd_req_ready;
  logic [AddressWidth-1:0] rd_req_addr;

  logic                    rd_resp_valid;
  logic [DataWidth-1:0]    rd_resp_data;

  modport master (
    output acc_valid, acc_addr, acc_data, rd_req_valid, rd_req_addr,
    input  acc_ready, rd_req_ready, rd_resp_valid, rd_resp_data
  );

  modport slave (
    input  acc_valid, acc_addr, acc_data, rd_req_valid, rd_req_addr,
    output acc_ready, rd_req_ready, rd_resp_valid, rd_resp_data
  );

endinterface

// File: rtl/fmm_reduce_rr_arb2.sv
// Two-requester round-robin arbiter with a registered priority pointer.
//   clk, reset       - clock, asynchronous active-high reset
//   en               - grants may be issued this cycle
//   req_acc, req_rd  - requests from the accumulate and readout streams
//   gnt_acc, gnt_rd  - one-hot (or zero) grant
// A sole requester always wins; the pointer only moves on a contested grant.
module fmm_reduce_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_acc,
  input  logic req_rd,
  output logic gnt_acc,
  output logic gnt_rd
);
  import fmm_reduce_pkg::*;

  op_e ptr_q, ptr_d;  // stream that wins the next contested cycle

  always_comb begin
    gnt_acc = 1'b0;
    gnt_rd  = 1'b0;
    ptr_d   = ptr_q;
    if (en) begin
      if (req_acc && req_rd) begin
        gnt_acc = (ptr_q == OP_ACC);
        gnt_rd  = (ptr_q == OP_RD);
        ptr_d   = (ptr_q == OP_ACC) ? OP_RD : OP_ACC;
      end else begin
        gnt_acc = req_acc;
        gnt_rd  = req_rd;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= OP_ACC;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fmm_reduce_kernel_m_e_accum_ctrl.sv
// M_e accumulation RAM sequencer for the fmm reduce kernel.
//   clk, reset        - clock, asynchronous active-high reset
//   cmd_clear         - single-cycle request to zero the whole RAM
//   busy              - high while draining or clearing
//   clear_done        - one-cycle pulse after the last clear write
//   bus               - accumulate / readout streams (slave side)
//   ram_*0            - RAM port 0, reads only (1-cycle latency)
//   ram_*1            - RAM port 1, accumulate write-back and clear sweep
// Two stages: S0 arbitrates and issues the port-0 read, S1 adds and writes back (or returns
// read data). A same-address ACC sitting in S1 is forwarded to the following op, since the RAM
// is read-first and that write is not yet visible.
module fmm_reduce_kernel_m_e_accum_ctrl #(
  parameter int unsigned DataWidth    = fmm_reduce_pkg::DataWidth,
  parameter int unsigned AddressWidth = fmm_reduce_pkg::AddressWidth,
  parameter int unsigned AddressRange = fmm_reduce_pkg::AddressRange
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_clear,
  output logic                     busy,
  output logic                     clear_done,
  fmm_reduce_kernel_m_e_accum_ctrl_if.slave bus,
  output logic [AddressWidth-1:0]  ram_address0,
  output logic                     ram_ce0,
  output logic                     ram_we0,
  output logic [DataWidth-1:0]     ram_d0,
  input  logic [DataWidth-1:0]     ram_q0,
  output logic [AddressWidth-1:0]  ram_address1,
  output logic                     ram_ce1,
  output logic                     ram_we1,
  output logic [DataWidth-1:0]     ram_d1
);
  import fmm_reduce_pkg::*;

  localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(AddressRange - 1);

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] cnt_q, cnt_d;
  logic                    clear_done_q, clear_done_d;

  logic                    s1_valid_q;
  op_e                     s1_op_q;
  logic [AddressWidth-1:0] s1_addr_q;
  logic [DataWidth-1:0]    s1_data_q;
  logic                    s1_fwd_q;
  logic [DataWidth-1:0]    last_sum_q;

  logic                    accept_en, gnt_acc, gnt_rd, s0_valid, s0_fwd;
  op_e                     s0_op;
  logic [AddressWidth-1:0] s0_addr;
  logic                    s1_acc, s1_rd;
  logic [DataWidth-1:0]    operand, sum;

  // A cmd_clear cycle accepts nothing, so the clear never races a fresh S1 entry.
  assign accept_en = (state_q == RUN) && !cmd_clear && !reset;

  fmm_reduce_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      (accept_en),
    .req_acc (bus.acc_valid),
    .req_rd  (bus.rd_req_valid),
    .gnt_acc (gnt_acc),
    .gnt_rd  (gnt_rd)
  );

  // S0: grant drives the port-0 read.
  always_comb begin
    s0_valid = gnt_acc || gnt_rd;
    s0_op    = gnt_rd ? OP_RD : OP_ACC;
    s0_addr  = gnt_rd ? bus.rd_req_addr : (gnt_acc ? bus.acc_addr : '0);
    s0_fwd   = s0_valid && s1_valid_q && (s1_op_q == OP_ACC) && (s1_addr_q == s0_addr);
  end

  assign bus.acc_ready    = gnt_acc;
  assign bus.rd_req_ready = gnt_rd;
  assign ram_ce0          = s0_valid;
  assign ram_address0     = s0_addr;
  assign ram_we0          = 1'b0;
  assign ram_d0           = '0;

  // S1: combine operand and addend; carry out is dropped.
  always_comb begin
    s1_acc  = s1_valid_q && (s1_op_q == OP_ACC);
    s1_rd   = s1_valid_q && (s1_op_q == OP_RD);
    operand = s1_fwd_q ? last_sum_q : ram_q0;
    sum     = operand + s1_data_q;
  end

  assign bus.rd_resp_valid = s1_rd;
  assign bus.rd_resp_data  = s1_rd ? operand : '0;

  always_comb begin
    ram_address1 = '0;
    ram_ce1      = 1'b0;
    ram_we1      = 1'b0;
    ram_d1       = '0;
    if (state_q == CLEAR) begin
      ram_address1 = cnt_q;
      ram_ce1      = 1'b1;
      ram_we1      = 1'b1;
    end else if (s1_acc) begin
      ram_address1 = s1_addr_q;
      ram_ce1      = 1'b1;
      ram_we1      = 1'b1;
      ram_d1       = sum;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clear_done_d = 1'b0;
    case (state_q)
      RUN: begin
        if (cmd_clear) state_d = s1_valid_q ? DRAIN : CLEAR;
      end
      DRAIN: begin
        if (!s1_valid_q) state_d = CLEAR;
      end
      CLEAR: begin
        if (cnt_q == LastAddr) begin
          cnt_d        = '0;
          clear_done_d = 1'b1;
          state_d      = RUN;
        end else begin
          cnt_d = cnt_q + AddressWidth'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign busy       = (state_q != RUN);
  assign clear_done = clear_done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      clear_done_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_op_q      <= OP_ACC;
      s1_addr_q    <= '0;
      s1_data_q    <= '0;
      s1_fwd_q     <= 1'b0;
      last_sum_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clear_done_q <= clear_done_d;
      s1_valid_q   <= s0_valid;
      if (s0_valid) begin
        s1_op_q   <= s0_op;
        s1_addr_q <= s0_addr;
        s1_data_q <= bus.acc_data;
        s1_fwd_q  <= s0_fwd;
      end
      if (s1_acc) last_sum_q <= sum;
    end
  end

endmodule

// File: tb/tb_fmm_reduce_kernel_m_e_accum_ctrl.sv
// Bench for the M_e accumulation controller. The RAM is a behavioural read-first dual-port
// array; a shadow copy holds the values the accumulate/readout streams should observe.
// A short AddressRange keeps the clear sweep small.
module tb_fmm_reduce_kernel_m_e_accum_ctrl;

  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 17;
  localparam int unsigned TbRange = 128;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_clear = 1'b0;
  logic          busy, clear_done;
  logic [AW-1:0] ram_address0, ram_address1;
  logic          ram_ce0, ram_we0, ram_ce1, ram_we1;
  logic [DW-1:0] ram_d0, ram_d1, ram_q0;

  logic [DW-1:0] mem       [TbRange];
  logic [DW-1:0] model_mem [TbRange];

  exp_t exp_wr[$];
  exp_t exp_rd[$];
  exp_t mon_e;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit in_sweep = 1'b0;

  fmm_reduce_kernel_m_e_accum_ctrl_if #(.DataWidth(DW), .AddressWidth(AW)) bus ();

  fmm_reduce_kernel_m_e_accum_ctrl #(
    .DataWidth    (DW),
    .AddressWidth (AW),
    .AddressRange (TbRange)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_clear    (cmd_clear),
    .busy         (busy),
    .clear_done   (clear_done),
    .bus          (bus),
    .ram_address0 (ram_address0),
    .ram_ce0      (ram_ce0),
    .ram_we0      (ram_we0),
    .ram_d0       (ram_d0),
    .ram_q0       (ram_q0),
    .ram_address1 (ram_address1),
    .ram_ce1      (ram_ce1),
    .ram_we1      (ram_we1),
    .ram_d1       (ram_d1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-first RAM: port 0 sees the old word on a same-edge collision.
  always @(posedge clk) begin
    if (ram_ce0) ram_q0 <= mem[ram_address0[6:0]];
    if (ram_ce1 && ram_we1) mem[ram_address1[6:0]] <= ram_d1;
  end

  // Scoreboard: every port-1 accumulate write and every read response is popped and compared.
  always @(negedge clk) begin
    if (!reset && bus.rd_resp_valid === 1'b1) begin
      checks++;
      if (exp_rd.size() == 0) begin
        failures++;
        $display("FAIL rd_resp unexpected: got data=%h at cyc %0d, required none", bus.rd_resp_data,
                 cyc);
      end else begin
        mon_e = exp_rd.pop_front();
        if (bus.rd_resp_data !== mon_e.data || cyc != mon_e.due) begin
          failures++;
          $display("FAIL rd_resp addr %0d: got data=%h cyc=%0d, required data=%h cyc=%0d",
                   mon_e.addr, bus.rd_resp_data, cyc, mon_e.data, mon_e.due);
        end
      end
    end
    if (!reset && !in_sweep && ram_ce1 === 1'b1 && ram_we1 === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL acc_write unexpected: got addr=%0d data=%h, required none", ram_address1,
                 ram_d1);
      end else begin
        mon_e = exp_wr.pop_front();
        if (ram_address1 !== mon_e.addr || ram_d1 !== mon_e.data || cyc != mon_e.due) begin
          failures++;
          $display("FAIL acc_write: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                   ram_address1, ram_d1, cyc, mon_e.addr, mon_e.data, mon_e.due);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic outs_nonzero();
    return busy | clear_done | bus.acc_ready | bus.rd_req_ready | bus.rd_resp_valid | ram_ce0 |
           ram_we0 | ram_ce1 | ram_we1 | (|ram_address0) | (|ram_address1) | (|ram_d0) |
           (|ram_d1) | (|bus.rd_resp_data);
  endfunction

  // One cycle of stimulus; accepted requests update the shadow model and push expectations.
  task automatic drive(input bit av, input int aa, input logic [DW-1:0] ad, input bit rv,
                       input int ra, output bit ag, output bit rg);
    exp_t e;
    @(posedge clk);
    #1;
    bus.acc_valid    = av;
    bus.acc_addr     = AW'(aa);
    bus.acc_data     = ad;
    bus.rd_req_valid = rv;
    bus.rd_req_addr  = AW'(ra);
    @(negedge clk);
    ag = av && (bus.acc_ready === 1'b1);
    rg = rv && (bus.rd_req_ready === 1'b1);
    if (ag) begin
      model_mem[aa] = model_mem[aa] + ad;
      e.addr = AW'(aa);
      e.data = model_mem[aa];
      e.due  = cyc + 1;
      exp_wr.push_back(e);
    end
    if (rg) begin
      e.addr = AW'(ra);
      e.data = model_mem[ra];
      e.due  = cyc + 1;
      exp_rd.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    bit a, r;
    repeat (n) drive(1'b0, 0, '0, 1'b0, 0, a, r);
  endtask

  task automatic test_reset();
    bus.acc_valid    = 1'b1;
    bus.acc_addr     = AW'(3);
    bus.acc_data     = 32'd1;
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = AW'(4);
    cmd_clear        = 1'b0;
    reset            = 1'b1;
    @(negedge clk);
    checks++;
    if (outs_nonzero() !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got some output nonzero, required all 0");
    end
    bus.acc_valid    = 1'b0;
    bus.rd_req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs_nonzero() !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got some output nonzero, required all 0");
    end
  endtask

  task automatic test_contention();
    bit ag, rg;
    int na = 0, nr = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 20 + i, DW'(i + 1), 1'b1, 21, ag, rg);
      na += int'(ag);
      nr += int'(rg);
      checks++;
      if ({ag, rg} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL contention_grant %0d: got acc/rd=%b%b, required %s", i, ag, rg,
                 (i % 2 == 0) ? "10" : "01");
      end
    end
    checks++;
    if (na != 2 || nr != 2) begin
      failures++;
      $display("FAIL contention_counts: got acc=%0d rd=%0d, required 2 and 2", na, nr);
    end
    idle(2);
  endtask

  task automatic test_single_acc();
    bit ag, rg;
    mem[5] = 32'd10;
    model_mem[5] = 32'd10;
    drive(1'b1, 5, 32'd3, 1'b0, 0, ag, rg);
    checks++;
    if (ag !== 1'b1) begin
      failures++;
      $display("FAIL single_acc_accept: got ready=%b, required 1", ag);
    end
    idle(2);
    drive(1'b0, 0, '0, 1'b1, 5, ag, rg);
    checks++;
    if (rg !== 1'b1) begin
      failures++;
      $display("FAIL single_rd_accept: got ready=%b, required 1", rg);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    bit ag, rg;
    int acc_ok = 0;
    mem[7] = '0;
    model_mem[7] = '0;
    drive(1'b1, 7, 32'd1, 1'b0, 0, ag, rg);
    acc_ok += int'(ag);
    drive(1'b1, 7, 32'd2, 1'b0, 0, ag, rg);
    acc_ok += int'(ag);
    drive(1'b1, 7, 32'd4, 1'b0, 0, ag, rg);
    acc_ok += int'(ag);
    checks++;
    if (acc_ok != 3) begin
      failures++;
      $display("FAIL back_to_back_accepts: got %0d, required 3", acc_ok);
    end
    idle(2);
    drive(1'b0, 0, '0, 1'b1, 7, ag, rg);
    idle(2);
  endtask

  task automatic test_read_behind_write();
    bit ag, rg;
    mem[9] = 32'd1;
    model_mem[9] = 32'd1;
    drive(1'b1, 9, 32'd5, 1'b0, 0, ag, rg);
    drive(1'b0, 0, '0, 1'b1, 9, ag, rg);
    checks++;
    if (rg !== 1'b1) begin
      failures++;
      $display("FAIL rbw_rd_accept: got ready=%b, required 1", rg);
    end
    idle(2);
  endtask

  task automatic test_wrap();
    bit ag, rg;
    mem[11] = 32'hFFFF_FFFF;
    model_mem[11] = 32'hFFFF_FFFF;
    drive(1'b1, 11, 32'd2, 1'b0, 0, ag, rg);
    idle(2);
    drive(1'b0, 0, '0, 1'b1, 11, ag, rg);
    idle(2);
  endtask

  task automatic test_clear();
    bit ag, rg;
    int idx = 0, pulses = 0, leaks = 0;
    mem[40] = 32'd123;
    model_mem[40] = 32'd123;
    drive(1'b1, 40, 32'd1, 1'b0, 0, ag, rg);
    @(posedge clk);
    #1;
    bus.acc_valid    = 1'b0;
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = AW'(40);
    cmd_clear        = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rd_req_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_cmd_cycle: got ready=%b busy=%b, required 0 0", bus.rd_req_ready,
               busy);
    end
    @(posedge clk);
    #1;
    cmd_clear = 1'b0;
    in_sweep  = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ram_ce1 !== 1'b0 || bus.rd_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL drain_cycle: got busy=%b ce1=%b ready=%b, required 1 0 0", busy, ram_ce1,
               bus.rd_req_ready);
    end
    for (int c = 0; c < int'(TbRange) + 10 && pulses == 0; c++) begin
      @(posedge clk);
      #1;
      cmd_clear        = (c == 3);
      bus.rd_req_valid = (c < 5);
      @(negedge clk);
      if (bus.rd_req_ready === 1'b1) leaks++;
      if (ram_ce1 === 1'b1 && ram_we1 === 1'b1) begin
        checks++;
        if (ram_address1 !== AW'(idx) || ram_d1 !== '0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL clear_write %0d: got addr=%0d data=%h busy=%b, required addr=%0d 0 1",
                   idx, ram_address1, ram_d1, busy, idx);
        end
        idx++;
      end
      if (clear_done === 1'b1) begin
        pulses++;
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL clear_done_busy: got busy=%b, required 0", busy);
        end
      end
    end
    in_sweep = 1'b0;
    cmd_clear = 1'b0;
    checks++;
    if (idx != int'(TbRange) || pulses != 1 || leaks != 0) begin
      failures++;
      $display("FAIL clear_sweep: got writes=%0d pulses=%0d leaks=%0d, required %0d 1 0", idx,
               pulses, leaks, TbRange);
    end
    @(negedge clk);
    checks++;
    if (clear_done !== 1'b0) begin
      failures++;
      $display("FAIL clear_done_single: got %b, required 0", clear_done);
    end
    for (int i = 0; i < int'(TbRange); i++) model_mem[i] = '0;
    drive(1'b0, 0, '0, 1'b1, 40, ag, rg);
    drive(1'b0, 0, '0, 1'b1, 5, ag, rg);
    idle(2);
  endtask

  task automatic test_reset_mid_clear();
    bit ag, rg, found = 1'b0, seen = 1'b0;
    mem[60] = 32'd99;
    model_mem[60] = 32'd99;
    @(posedge clk);
    #1;
    cmd_clear = 1'b1;
    in_sweep  = 1'b1;
    @(posedge clk);
    #1 cmd_clear = 1'b0;
    for (int c = 0; c < 2 * int'(TbRange) && !found; c++) begin
      @(negedge clk);
      if (ram_ce1 === 1'b1 && ram_address1 === AW'(20)) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mid_clear_reach: got cnt 20 not seen, required seen");
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (outs_nonzero() !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort_outputs: got busy=%b ce1=%b addr1=%0d, required all 0", busy,
               ram_ce1, ram_address1);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    in_sweep = 1'b0;
    // Sweep aborted at word 20: higher words keep their contents.
    drive(1'b0, 0, '0, 1'b1, 60, ag, rg);
    drive(1'b0, 0, '0, 1'b1, 3, ag, rg);
    idle(2);
    @(posedge clk);
    #1;
    cmd_clear = 1'b1;
    in_sweep  = 1'b1;
    @(posedge clk);
    #1 cmd_clear = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_ce1 !== 1'b1 || ram_address1 !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_from_zero: got ce1=%b addr=%0d busy=%b, required 1 0 1", ram_ce1,
               ram_address1, busy);
    end
    for (int c = 0; c < int'(TbRange) + 5 && !seen; c++) begin
      @(negedge clk);
      if (clear_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL restart_clear_done: got no pulse, required pulse");
    end
    in_sweep = 1'b0;
    for (int i = 0; i < int'(TbRange); i++) model_mem[i] = '0;
    drive(1'b0, 0, '0, 1'b1, 60, ag, rg);
    idle(2);
  endtask

  task automatic test_scoreboard_empty();
    idle(3);
    checks++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got wr=%0d rd=%0d pending, required 0 0", exp_wr.size(),
               exp_rd.size());
    end
  endtask

  initial begin
    for (int i = 0; i < int'(TbRange); i++) begin
      mem[i]       = '0;
      model_mem[i] = '0;
    end
    test_reset();
    test_contention();
    test_single_acc();
    test_back_to_back();
    test_read_behind_write();
    test_wrap();
    test_clear();
    test_reset_mid_clear();
    test_scoreboard_empty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
